// File: rtl/systolic_pkg.sv
// Shared constants and FSM encoding for the systolic operand feeder.
package systolic_pkg;
  localparam int SYS_N        = 4;
  localparam int SYS_DW       = 32;
  localparam int SYS_FEED_LEN = 2 * SYS_N - 1;
  localparam int SYS_DRAIN    = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/systolic_feeder_skew_mux.sv
// One edge lane: picks word (t - lane) of the lane's four stored words,
// or zero when the diagonal skew puts this lane outside its active window.
module skew_mux
  import systolic_pkg::*;
#(
  parameter int DW = SYS_DW,
  parameter int N  = SYS_N
) (
  input  logic [N-1:0][DW-1:0] i_words,
  input  logic [1:0]           i_lane,
  input  logic [2:0]           i_t,
  output logic [DW-1:0]        o_val
);
  localparam logic signed [3:0] LAST = 4'(N - 1);

  logic signed [3:0] w_d;

  // Signed 4-bit offset so t < lane shows up as negative rather than wrapping.
  assign w_d = $signed({1'b0, i_t}) - $signed({2'b00, i_lane});

  // Zero-fill outside 0..N-1, otherwise pass the selected word through.
  always_comb begin
    o_val = '0;
    if (!w_d[3] && (w_d <= LAST)) o_val = i_words[w_d[1:0]];
  end
endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for a 4x4 output-stationary systolic array: holds A and B,
// clears the array, streams skewed rows/columns, waits for drain, pulses done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DW    = SYS_DW,
  parameter int N     = SYS_N,
  parameter int DRAIN = SYS_DRAIN
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          wr_en,
  input  logic          wr_sel,
  input  logic [3:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          arr_clear,
  output logic [DW-1:0] left0,
  output logic [DW-1:0] left1,
  output logic [DW-1:0] left2,
  output logic [DW-1:0] left3,
  output logic [DW-1:0] up0,
  output logic [DW-1:0] up1,
  output logic [DW-1:0] up2,
  output logic [DW-1:0] up3
);
  // Counter is 3 bits: covers t = 0..6 and drain lengths up to 8.
  localparam logic [2:0] FEED_LAST  = 3'(2 * N - 2);
  localparam logic [2:0] DRAIN_LAST = 3'(DRAIN - 1);

  state_e r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;

  logic [N*N-1:0][DW-1:0] r_mem_a, r_mem_b;
  logic [N-1:0][DW-1:0]   r_left, r_up;
  logic [N-1:0][DW-1:0]   w_left, w_up;
  logic [N-1:0][N-1:0][DW-1:0] w_row_words, w_col_words;

  // State and time counter register; reset aborts any pass in flight.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state, counter and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    done        = 1'b0;
    arr_clear   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (start) w_state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        busy        = 1'b1;
        arr_clear   = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_FEED;
      end
      S_FEED: begin
        busy = 1'b1;
        if (r_cnt == FEED_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (r_cnt == DRAIN_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand storage; writes land only while idle so a pass sees a stable matrix.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_mem_a <= '0;
      r_mem_b <= '0;
    end else if (wr_en && (r_state == S_IDLE)) begin
      if (wr_sel) r_mem_b[wr_addr] <= wr_data;
      else        r_mem_a[wr_addr] <= wr_data;
    end
  end

  // Row k of A feeds west lane k; column k of B feeds north lane k.
  for (genvar k = 0; k < N; k++) begin : g_lane
    for (genvar e = 0; e < N; e++) begin : g_word
      assign w_row_words[k][e] = r_mem_a[k*N + e];
      assign w_col_words[k][e] = r_mem_b[e*N + k];
    end
    skew_mux #(.DW(DW), .N(N)) u_row (
      .i_words (w_row_words[k]),
      .i_lane  (2'(k)),
      .i_t     (r_cnt),
      .o_val   (w_left[k])
    );
    skew_mux #(.DW(DW), .N(N)) u_col (
      .i_words (w_col_words[k]),
      .i_lane  (2'(k)),
      .i_t     (r_cnt),
      .o_val   (w_up[k])
    );
  end

  // Edge registers: live values only while feeding, zero in every other state.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_left <= '0;
      r_up   <= '0;
    end else if (r_state == S_FEED) begin
      r_left <= w_left;
      r_up   <= w_up;
    end else begin
      r_left <= '0;
      r_up   <= '0;
    end
  end

  assign left0 = r_left[0];
  assign left1 = r_left[1];
  assign left2 = r_left[2];
  assign left3 = r_left[3];
  assign up0   = r_up[0];
  assign up1   = r_up[1];
  assign up2   = r_up[2];
  assign up3   = r_up[3];
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder, with a behavioural 4x4 array on its outputs.
module tb_systolic_feeder;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Reset, wr_en, wr_sel, start;
  logic [3:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done, arr_clear;
  logic [DW-1:0] left0, left1, left2, left3, up0, up1, up2, up3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  systolic_feeder dut (
    .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .busy(busy), .done(done), .arr_clear(arr_clear),
    .left0(left0), .left1(left1), .left2(left2), .left3(left3),
    .up0(up0), .up1(up1), .up2(up2), .up3(up3)
  );

  logic [DW-1:0] lft[4], upv[4];
  assign lft[0] = left0; assign lft[1] = left1; assign lft[2] = left2; assign lft[3] = left3;
  assign upv[0] = up0;   assign upv[1] = up1;   assign upv[2] = up2;   assign upv[3] = up3;

  // Output-stationary array model: a moves east, b moves south, each PE accumulates a*b.
  logic [31:0] m_a[4][4], m_b[4][4], m_acc[4][4], m_ain[4][4], m_bin[4][4];
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      m_ain[i][0] = lft[i];
      m_bin[0][i] = upv[i];
      for (int j = 1; j < 4; j++) begin
        m_ain[i][j] = m_a[i][j-1];
        m_bin[j][i] = m_b[j-1][i];
      end
    end
  end
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (!Reset || arr_clear) begin
          m_a[i][j] <= '0; m_b[i][j] <= '0; m_acc[i][j] <= '0;
        end else begin
          m_a[i][j]   <= m_ain[i][j];
          m_b[i][j]   <= m_bin[i][j];
          m_acc[i][j] <= m_acc[i][j] + m_ain[i][j] * m_bin[i][j];
        end
  end

  // Capture of one pass: cycle numbers counted from the start-sampling edge.
  logic [DW-1:0] cap_l[4][7], cap_u[4][7];
  int cap_clr, cap_clr2, cap_done, cap_done2, cap_ndone;

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic wr(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run_pass(input int ncyc, input bit inject, input bit hold_start);
    cap_clr = 0; cap_clr2 = 0; cap_done = 0; cap_done2 = 0; cap_ndone = 0;
    start = 1'b1;
    tick();
    wr_en = 1'b0;
    if (!hold_start) start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      if (arr_clear) begin
        if (cap_clr == 0) cap_clr = c; else if (cap_clr2 == 0) cap_clr2 = c;
      end
      if (done) begin
        cap_ndone++;
        if (cap_done == 0) cap_done = c; else if (cap_done2 == 0) cap_done2 = c;
      end
      if (c >= 3 && c <= 9)
        for (int k = 0; k < 4; k++) begin
          cap_l[k][c-3] = lft[k];
          cap_u[k][c-3] = upv[k];
        end
      if (inject && c == 4) begin
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 99; start = 1'b1;
      end else if (inject && c == 5) begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (hold_start && c == 20) start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", done); end
    n_cmp++; if (arr_clear !== 1'b0) begin n_bad++; $display("FAIL reset_clear: got %0b want 0", arr_clear); end
    n_cmp++;
    if ((left0 | left1 | left2 | left3 | up0 | up1 | up2 | up3) !== '0) begin
      n_bad++; $display("FAIL reset_edges: some edge nonzero (left0=%0d up0=%0d) want 0", left0, up0);
    end
  endtask

  task automatic test_identity();
    int exp_up0[7]   = '{1, 5, 9, 13, 0, 0, 0};
    int exp_left3[7] = '{0, 0, 0, 0, 0, 0, 1};
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        wr(1'b0, 4'(4*r + c), (r == c) ? 32'd1 : 32'd0);
        wr(1'b1, 4'(4*r + c), 32'(4*r + c + 1));
      end
    run_pass(20, 1'b0, 1'b0);
    n_cmp++; if (cap_clr !== 1) begin n_bad++; $display("FAIL id_clear_cycle: got %0d want 1", cap_clr); end
    n_cmp++; if (cap_done !== 13) begin n_bad++; $display("FAIL id_done_cycle: got %0d want 13", cap_done); end
    n_cmp++; if (cap_ndone !== 1) begin n_bad++; $display("FAIL id_done_count: got %0d want 1", cap_ndone); end
    for (int t = 0; t < 7; t++) begin
      n_cmp++;
      if (cap_u[0][t] !== DW'(exp_up0[t])) begin
        n_bad++; $display("FAIL id_up0[t=%0d]: got %0d want %0d", t, cap_u[0][t], exp_up0[t]);
      end
      n_cmp++;
      if (cap_l[3][t] !== DW'(exp_left3[t])) begin
        n_bad++; $display("FAIL id_left3[t=%0d]: got %0d want %0d", t, cap_l[3][t], exp_left3[t]);
      end
    end
  endtask

  task automatic test_skew();
    int exp_l0[7] = '{16, 17, 18, 19, 0, 0, 0};
    int exp_l2[7] = '{0, 0, 24, 25, 26, 27, 0};
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 4'(i), 32'(16 + i));
      wr(1'b1, 4'(i), 32'd0);
    end
    run_pass(20, 1'b0, 1'b0);
    for (int t = 0; t < 7; t++) begin
      n_cmp++;
      if (cap_l[0][t] !== DW'(exp_l0[t])) begin
        n_bad++; $display("FAIL skew_left0[t=%0d]: got %0d want %0d", t, cap_l[0][t], exp_l0[t]);
      end
      n_cmp++;
      if (cap_l[2][t] !== DW'(exp_l2[t])) begin
        n_bad++; $display("FAIL skew_left2[t=%0d]: got %0d want %0d", t, cap_l[2][t], exp_l2[t]);
      end
      n_cmp++;
      if ((cap_u[0][t] | cap_u[1][t] | cap_u[2][t] | cap_u[3][t]) !== '0) begin
        n_bad++; $display("FAIL skew_up_zero[t=%0d]: got nonzero want 0", t);
      end
    end
  endtask

  task automatic test_busy_reject();
    run_pass(24, 1'b1, 1'b0);
    n_cmp++; if (cap_ndone !== 1) begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", cap_ndone); end
    n_cmp++; if (cap_done !== 13) begin n_bad++; $display("FAIL busy_done_cycle: got %0d want 13", cap_done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_no_requeue: busy=%0b want 0", busy); end
    run_pass(20, 1'b0, 1'b0);
    n_cmp++; if (cap_l[0][0] !== 32'd16) begin n_bad++; $display("FAIL busy_storage: left0 t0 got %0d want 16", cap_l[0][0]); end
  endtask

  task automatic test_reset_midfeed();
    int nd = 0;
    start = 1'b1;
    tick();                       // cycle 1: CLEAR
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();   // cycle 5: FEED t=3, edges show t=2
    n_cmp++; if (left0 !== 32'd18) begin n_bad++; $display("FAIL rst_pre_left0: got %0d want 18", left0); end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    n_cmp++;
    if ((left0 | left1 | left2 | left3 | up0 | up1 | up2 | up3) !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_outputs: left0=%0d busy=%0b want 0/0", left0, busy);
    end
    for (int c = 0; c < 20; c++) begin
      if (done) nd++;
      tick();
    end
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL rst_no_done: got %0d pulses want 0", nd); end
    run_pass(20, 1'b0, 1'b0);
    n_cmp++; if (cap_done !== 13) begin n_bad++; $display("FAIL rst_fresh_done: got %0d want 13", cap_done); end
    for (int k = 0; k < 4; k++)
      for (int t = 0; t < 7; t++) begin
        n_cmp++;
        if ((cap_l[k][t] | cap_u[k][t]) !== '0) begin
          n_bad++; $display("FAIL rst_zero_lane%0d[t=%0d]: left=%0d up=%0d want 0", k, t, cap_l[k][t], cap_u[k][t]);
        end
      end
  endtask

  task automatic test_write_with_start();
    int exp_l1[7] = '{0, 0, 7, 0, 0, 0, 0};
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd5; wr_data = 32'd7;
    run_pass(20, 1'b0, 1'b0);
    for (int t = 0; t < 7; t++) begin
      n_cmp++;
      if (cap_l[1][t] !== DW'(exp_l1[t])) begin
        n_bad++; $display("FAIL wrstart_left1[t=%0d]: got %0d want %0d", t, cap_l[1][t], exp_l1[t]);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_pass(32, 1'b0, 1'b1);
    n_cmp++; if (cap_done !== 13) begin n_bad++; $display("FAIL b2b_done1: got %0d want 13", cap_done); end
    n_cmp++; if (cap_clr2 !== 15) begin n_bad++; $display("FAIL b2b_clear2: got %0d want 15", cap_clr2); end
    n_cmp++; if (cap_done2 !== 27) begin n_bad++; $display("FAIL b2b_done2: got %0d want 27", cap_done2); end
  endtask

  task automatic test_array();
    logic [31:0] ra[16], rb[16], rc;
    for (int i = 0; i < 16; i++) begin
      ra[i] = $urandom_range(0, 255);
      rb[i] = $urandom_range(0, 255);
      wr(1'b0, 4'(i), ra[i]);
      wr(1'b1, 4'(i), rb[i]);
    end
    run_pass(20, 1'b0, 1'b0);
    n_cmp++; if (cap_done !== 13) begin n_bad++; $display("FAIL arr_done: got %0d want 13", cap_done); end
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        rc = 0;
        for (int k = 0; k < 4; k++) rc += ra[4*i + k] * rb[4*k + j];
        n_cmp++;
        if (m_acc[i][j] !== rc) begin
          n_bad++; $display("FAIL arr_C[%0d][%0d]: got %0d want %0d", i, j, m_acc[i][j], rc);
        end
      end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_busy_reject();
    test_reset_midfeed();
    test_write_with_start();
    test_back_to_back();
    test_array();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
